// File: rtl/sop_pkg.sv
// Shared types and helpers for the sum-of-products table scanner.
package sop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN
  } sop_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sop_popcount.sv
// Combinational population count of a W-bit vector; W itself is representable.
module sop_popcount #(
  parameter int W = 4
) (
  input  logic [W-1:0]       i_vec,
  output logic [$clog2(W):0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + {{$clog2(W){1'b0}}, i_vec[i]};
    end
  end

endmodule

// File: rtl/sop_table_scanner.sv
// Programmable N-input sum-of-products evaluator with serial table load and row scan.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting; eval path live, cfg_start / scan_start accepted
// LOAD    | shifting table bits in, minterm 0 first; eval_out held at 0
// SCAN    | presenting one truth-table row per row_valid/row_ready handshake
module sop_table_scanner
  import sop_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            table_ok,
  input  logic [N_IN-1:0] eval_in,
  output logic            eval_out,
  output logic [N_IN:0]   minterm_cnt,
  input  logic            scan_start,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [N_IN-1:0] row_idx,
  output logic            row_f,
  output logic            row_last,
  output logic            busy
);

  localparam int TBL_W = 2 ** N_IN;
  localparam int CNT_W = clog2(TBL_W) + 1;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TBL_W - 1);

  sop_state_t       r_state;
  logic [TBL_W-1:0] r_table;
  logic [N_IN-1:0]  r_load_idx;
  logic [N_IN-1:0]  r_row_idx;
  logic             r_table_ok;
  logic             r_eval_out;
  logic [N_IN:0]    r_minterm_cnt;
  logic             r_cfg_ready;
  logic             r_row_valid;
  logic             r_busy;

  logic [TBL_W-1:0] w_table_nxt;
  logic [CNT_W-1:0] w_pop;
  logic             w_load_enter;
  logic             w_load_last;
  logic             w_eval_zero;

  // Count the table including the bit being accepted, so minterm_cnt and
  // table_ok become visible together right after the final bit.
  always_comb begin
    w_table_nxt             = r_table;
    w_table_nxt[r_load_idx] = cfg_bit;
  end

  sop_popcount #(.W(TBL_W)) u_popcount (
    .i_vec (w_table_nxt),
    .o_cnt (w_pop)
  );

  assign w_load_enter = (r_state == ST_IDLE) && cfg_start;
  assign w_load_last  = (r_state == ST_LOAD) && cfg_valid && (r_load_idx == LAST_IDX);
  assign w_eval_zero  = w_load_enter || (r_state == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_table       <= '0;
      r_load_idx    <= '0;
      r_row_idx     <= '0;
      r_table_ok    <= 1'b0;
      r_eval_out    <= 1'b0;
      r_minterm_cnt <= '0;
      r_cfg_ready   <= 1'b0;
      r_row_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_eval_out <= w_eval_zero ? 1'b0 : r_table[eval_in];
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_state     <= ST_LOAD;
            r_load_idx  <= '0;
            r_table_ok  <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
          end else if (scan_start && r_table_ok) begin
            r_state     <= ST_SCAN;
            r_row_idx   <= '0;
            r_row_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (cfg_valid) begin
            r_table <= w_table_nxt;
            if (w_load_last) begin
              r_state       <= ST_IDLE;
              r_table_ok    <= 1'b1;
              r_minterm_cnt <= w_pop;
              r_cfg_ready   <= 1'b0;
              r_busy        <= 1'b0;
            end else begin
              r_load_idx <= r_load_idx + 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (row_ready) begin
            if (r_row_idx == LAST_IDX) begin
              r_state     <= ST_IDLE;
              r_row_valid <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_row_idx <= r_row_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign table_ok    = r_table_ok;
  assign eval_out    = r_eval_out;
  assign minterm_cnt = r_minterm_cnt;
  assign row_valid   = r_row_valid;
  assign row_idx     = r_row_idx;
  assign row_f       = r_table[r_row_idx];
  assign row_last    = r_row_valid && (r_row_idx == LAST_IDX);
  assign busy        = r_busy;

endmodule

// File: tb/tb_sop_table_scanner.sv
// Directed bench: N_IN=2 instance for the main scenarios, N_IN=3 instance for majority.
module tb_sop_table_scanner;

  logic       clk;
  logic       rst_n;
  logic       cfg_start, cfg_valid, cfg_bit, scan_start, row_ready;
  logic [1:0] eval_in;
  logic       cfg_ready, table_ok, eval_out, row_valid, row_f, row_last, busy;
  logic [2:0] minterm_cnt;
  logic [1:0] row_idx;

  logic       b_cfg_start, b_cfg_valid, b_cfg_bit, b_scan_start, b_row_ready;
  logic [2:0] b_eval_in;
  logic       b_cfg_ready, b_table_ok, b_eval_out, b_row_valid, b_row_f, b_row_last, b_busy;
  logic [3:0] b_minterm_cnt;
  logic [2:0] b_row_idx;

  int n_checks = 0;
  int n_fail   = 0;

  sop_table_scanner #(.N_IN(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .table_ok(table_ok),
    .eval_in(eval_in), .eval_out(eval_out), .minterm_cnt(minterm_cnt),
    .scan_start(scan_start), .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .row_f(row_f), .row_last(row_last), .busy(busy)
  );

  sop_table_scanner #(.N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(b_cfg_start), .cfg_valid(b_cfg_valid), .cfg_bit(b_cfg_bit),
    .cfg_ready(b_cfg_ready), .table_ok(b_table_ok),
    .eval_in(b_eval_in), .eval_out(b_eval_out), .minterm_cnt(b_minterm_cnt),
    .scan_start(b_scan_start), .row_valid(b_row_valid), .row_ready(b_row_ready),
    .row_idx(b_row_idx), .row_f(b_row_f), .row_last(b_row_last), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [15:0] bits, input int n);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = bits[i];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({cfg_ready, table_ok, eval_out, row_valid, busy, row_last} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {cfg_ready, table_ok, eval_out, row_valid, busy, row_last});
    end
    n_checks++;
    if (minterm_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_minterm_cnt: got %0d expected 0", minterm_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_scan_before_load();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || row_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_ignored: busy=%b row_valid=%b expected 0 0", busy, row_valid);
    end
  endtask

  task automatic test_load_eval_xor();
    logic [3:0] bits;
    logic [3:0] fexp;
    bits = 4'b0110;
    fexp = 4'b0110;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_entry: cfg_ready=%b busy=%b expected 1 1", cfg_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = bits[i];
      tick();
      if (i == 1) begin
        cfg_valid = 1'b0;
        tick();
        n_checks++;
        if (cfg_ready !== 1'b1 || table_ok !== 1'b0) begin
          n_fail++;
          $display("FAIL load_stall: cfg_ready=%b table_ok=%b expected 1 0", cfg_ready, table_ok);
        end
      end
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (table_ok !== 1'b1 || minterm_cnt !== 3'd2 || cfg_ready !== 1'b0 || eval_out !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: table_ok=%b cnt=%0d cfg_ready=%b eval_out=%b expected 1 2 0 0",
               table_ok, minterm_cnt, cfg_ready, eval_out);
    end
    for (int v = 0; v < 4; v++) begin
      eval_in = 2'(v);
      tick();
      n_checks++;
      if (eval_out !== fexp[v]) begin
        n_fail++;
        $display("FAIL eval_xor[%0d]: got %b expected %b", v, eval_out, fexp[v]);
      end
    end
  endtask

  task automatic test_scan_streaming();
    logic [3:0] fexp;
    fexp = 4'b0110;
    row_ready  = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(i) || row_f !== fexp[i] || row_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL scan_row[%0d]: valid=%b idx=%0d f=%b last=%b expected 1 %0d %b %b",
                 i, row_valid, row_idx, row_f, row_last, i, fexp[i], (i == 3));
      end
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || row_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_exit: busy=%b row_valid=%b expected 0 0", busy, row_valid);
    end
    row_ready = 1'b0;
  endtask

  task automatic test_scan_backpressure();
    logic [3:0] fexp;
    int         seen;
    fexp = 4'b0110;
    seen = 0;
    row_ready  = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        for (int s = 0; s < 3; s++) begin
          n_checks++;
          if (row_valid !== 1'b1 || row_idx !== 2'd1 || row_f !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: valid=%b idx=%0d f=%b expected 1 1 1",
                     s, row_valid, row_idx, row_f);
          end
          tick();
        end
      end
      row_ready = 1'b1;
      if (row_valid === 1'b1 && row_idx === 2'(i) && row_f === fexp[i]) seen++;
      tick();
      row_ready = 1'b0;
    end
    n_checks++;
    if (seen != 4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_sequence: rows_in_order=%0d busy=%b expected 4 0", seen, busy);
    end
  endtask

  task automatic test_start_priority();
    eval_in = 2'b01;
    tick();
    n_checks++;
    if (eval_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_priority_eval: got %b expected 1", eval_out);
    end
    cfg_start  = 1'b1;
    scan_start = 1'b1;
    tick();
    cfg_start  = 1'b0;
    scan_start = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b1 || row_valid !== 1'b0 || table_ok !== 1'b0 || eval_out !== 1'b0) begin
      n_fail++;
      $display("FAIL start_priority: cfg_ready=%b row_valid=%b table_ok=%b eval_out=%b expected 1 0 0 0",
               cfg_ready, row_valid, table_ok, eval_out);
    end
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = (i == 1 || i == 2);
      tick();
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (eval_out !== 1'b0 || table_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL load_exit_eval: eval_out=%b table_ok=%b expected 0 1", eval_out, table_ok);
    end
    tick();
    n_checks++;
    if (eval_out !== 1'b1) begin
      n_fail++;
      $display("FAIL post_load_eval: got %b expected 1", eval_out);
    end
  endtask

  task automatic test_reset_mid_load();
    load1(16'h0003, 2);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (table_ok !== 1'b0 || eval_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0 || minterm_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_load_reset: table_ok=%b eval_out=%b busy=%b cfg_ready=%b cnt=%0d expected 0 0 0 0 0",
               table_ok, eval_out, busy, cfg_ready, minterm_cnt);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    eval_in = 2'b01;
    tick();
    n_checks++;
    if (eval_out !== 1'b0) begin
      n_fail++;
      $display("FAIL table_cleared: eval_out=%b expected 0", eval_out);
    end
    load1(16'h000F, 4);
    n_checks++;
    if (minterm_cnt !== 3'd4 || table_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL full_table: cnt=%0d table_ok=%b expected 4 1", minterm_cnt, table_ok);
    end
    eval_in = 2'b00;
    tick();
    n_checks++;
    if (eval_out !== 1'b1) begin
      n_fail++;
      $display("FAIL full_eval: got %b expected 1", eval_out);
    end
  endtask

  task automatic test_majority_n3();
    logic [7:0] tbl;
    tbl = 8'hE8;
    b_cfg_start = 1'b1;
    tick();
    b_cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_cfg_valid = 1'b1;
      b_cfg_bit   = tbl[i];
      tick();
    end
    b_cfg_valid = 1'b0;
    n_checks++;
    if (b_minterm_cnt !== 4'd4 || b_table_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL maj_load: cnt=%0d table_ok=%b expected 4 1", b_minterm_cnt, b_table_ok);
    end
    b_eval_in = 3'b011;
    tick();
    n_checks++;
    if (b_eval_out !== 1'b1) begin
      n_fail++;
      $display("FAIL maj_eval_011: got %b expected 1", b_eval_out);
    end
    b_eval_in = 3'b100;
    tick();
    n_checks++;
    if (b_eval_out !== 1'b0) begin
      n_fail++;
      $display("FAIL maj_eval_100: got %b expected 0", b_eval_out);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    scan_start = 1'b0; row_ready = 1'b0; eval_in = 2'b00;
    b_cfg_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_bit = 1'b0;
    b_scan_start = 1'b0; b_row_ready = 1'b0; b_eval_in = 3'b000;

    test_reset();
    test_scan_before_load();
    test_load_eval_xor();
    test_scan_streaming();
    test_scan_backpressure();
    test_start_priority();
    test_reset_mid_load();
    test_majority_n3();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
